// File: rtl/gf227_pkg.sv
// gf227_pkg
// Shared constants, state encoding and helpers for the GF(227) modular
// multiplier datapath.
//   Q      : field modulus (2^(W-1) < Q < 2^W)
//   W      : residue width in bits
//   ACC_W  : width of the un-reduced step sum 2*acc + a (< 3*Q)
//   IDX_W  : width of the multiplier bit index
package gf227_pkg;

    localparam int Q     = 227;
    localparam int W     = 8;
    localparam int ACC_W = W + 2;
    localparam int IDX_W = $clog2(W);

    localparam logic [W-1:0]     Q_W    = W'(Q);
    localparam logic [ACC_W-1:0] Q_ACC  = ACC_W'(Q);
    localparam logic [ACC_W-1:0] Q2_ACC = ACC_W'(2 * Q);
    // Low W bits of 2Q: subtracting it modulo 2^W gives the exact result
    // whenever the true difference is known to be below 2^W.
    localparam logic [W-1:0]     Q2_W   = Q2_ACC[W-1:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bring any W-bit value into 0..Q-1. A single subtract is enough
    // because 2^W - 1 < 2Q.
    function automatic logic [W-1:0] pre_reduce(input logic [W-1:0] x);
        return (x >= Q_W) ? (x - Q_W) : x;
    endfunction

endpackage

// File: rtl/gf_modstep.sv
// gf_modstep
// One combinational iteration of the MSB-first interleaved modular multiply:
//   acc_next = (2*acc + (b_bit ? a_r : 0)) mod Q
// With acc < Q and a_r < Q the sum is below 3Q, so at most two modulus
// subtractions bring it back into range.
// Ports:
//   acc      : current accumulator, 0..Q-1
//   a_r      : reduced multiplicand, 0..Q-1
//   b_bit    : current multiplier bit
//   acc_next : next accumulator, 0..Q-1
module gf_modstep
    import gf227_pkg::*;
(
    input  logic [W-1:0] acc,
    input  logic [W-1:0] a_r,
    input  logic         b_bit,
    output logic [W-1:0] acc_next
);

    logic [W-1:0]     addend;
    logic [ACC_W-1:0] sum;

    // Gate the multiplicand by the current multiplier bit.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_mask
            assign addend[gi] = a_r[gi] & b_bit;
        end
    endgenerate

    assign sum = {1'b0, acc, 1'b0} + {2'b00, addend};

    // The reduced result always fits in W bits, so the subtraction is done
    // on the low W bits only; the wide sum is needed just for the compares.
    always_comb begin
        acc_next = sum[W-1:0];
        if (sum >= Q2_ACC) begin
            acc_next = sum[W-1:0] - Q2_W;
        end else if (sum >= Q_ACC) begin
            acc_next = sum[W-1:0] - Q_W;
        end
    end

endmodule

// File: rtl/gf227_modmul_seq.sv
// gf227_modmul_seq
// Sequential modular multiplier over GF(227). Accepts one operand pair via a
// valid/ready handshake, runs W shift-add-reduce iterations (MSB first) and
// presents the fully reduced product until the consumer takes it. One
// product is in flight at a time.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : operand pair valid
//   in_ready  : high only while idle
//   in_a      : multiplicand, any W-bit value
//   in_b      : multiplier, any W-bit value
//   out_valid : out_r holds a completed product
//   out_ready : consumer accepts out_r
//   out_r     : (in_a * in_b) mod Q
module gf227_modmul_seq
    import gf227_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_r
);

    state_t           state_reg;
    state_t           state_next;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     acc_reg;
    logic [W-1:0]     out_r_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [W-1:0]     step_acc;

    gf_modstep u_step (
        .acc      (acc_reg),
        .a_r      (a_reg),
        .b_bit    (b_reg[idx_reg]),
        .acc_next (step_acc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid)               state_next = ST_RUN;
            ST_RUN:  if (idx_reg == '0)          state_next = ST_DONE;
            ST_DONE: if (out_ready)              state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
    end

    // Outputs depend on state only, so they never combinationally follow
    // the input handshake signals.
    always_comb begin
        in_ready  = (state_reg == ST_IDLE);
        out_valid = (state_reg == ST_DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            out_r_reg <= '0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg   <= pre_reduce(in_a);
                        b_reg   <= pre_reduce(in_b);
                        acc_reg <= '0;
                        idx_reg <= IDX_W'(W - 1);
                    end
                end
                ST_RUN: begin
                    acc_reg <= step_acc;
                    idx_reg <= idx_reg - 1'b1;
                    if (idx_reg == '0) begin
                        out_r_reg <= step_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_r = out_r_reg;

endmodule

// File: tb/tb_gf227_modmul_seq.sv
// tb_gf227_modmul_seq
// Directed self-checking bench for gf227_modmul_seq. Each scenario task
// drives its own stimulus and compares against hand-computed residues.
module tb_gf227_modmul_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_r;

    int checks = 0;
    int errors = 0;

    gf227_modmul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r)
    );

    always #5 clk = ~clk;

    // Present operands and wait (bounded) for the accept edge. Returns 1#
    // after that edge with in_valid dropped and the operand buses scrambled
    // so any late sampling would corrupt the result.
    task automatic accept(input logic [7:0] a, input logic [7:0] b, output bit ok);
        ok       = 1'b0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        #1;
        in_valid = 1'b0;
        in_a     = 8'hA5;
        in_b     = 8'h5A;
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_r !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_r=%0d, required 1 0 0",
                     in_ready, out_valid, out_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset: in_ready=%b out_valid=%b out_r=%0d", in_ready, out_valid, out_r);
    endtask

    task automatic test_basic();
        bit ok;
        int lat;
        bit ready_seen;
        out_ready  = 1'b1;
        lat        = -1;
        ready_seen = 1'b0;
        accept(8'd3, 8'd5, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_accept: no accept, required accept within bound");
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (in_ready) ready_seen = 1'b1;
            if (out_valid && lat < 0) lat = c;
        end
        checks++;
        if (ready_seen) begin
            errors++;
            $display("FAIL basic_in_ready: in_ready went high during RUN/DONE, required 0");
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL basic_latency: out_valid after %0d edges, required 8", lat);
        end
        checks++;
        if (out_r !== 8'd15) begin
            errors++;
            $display("FAIL basic_result: out_r=%0d, required 15", out_r);
        end
        $display("basic: a=3 b=5 out_r=%0d latency=%0d", out_r, lat);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_handshake: out_valid=%b in_ready=%b, required 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_products();
        logic [7:0] va [7] = '{8'd226, 8'd200, 8'd255, 8'd255, 8'd227, 8'd0,   8'd1};
        logic [7:0] vb [7] = '{8'd226, 8'd150, 8'd1,   8'd255, 8'd9,   8'd226, 8'd0};
        logic [7:0] ve [7] = '{8'd1,   8'd36,  8'd28,  8'd103, 8'd0,   8'd0,   8'd0};
        bit ok;
        int lat;
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            accept(va[k], vb[k], ok);
            wait_valid(lat);
            checks++;
            if (!ok || lat != 8) begin
                errors++;
                $display("FAIL product_latency[%0d]: accepted=%b latency=%0d, required 1 8",
                         k, ok, lat);
            end
            checks++;
            if (out_r !== ve[k]) begin
                errors++;
                $display("FAIL product[%0d]: a=%0d b=%0d out_r=%0d, required %0d",
                         k, va[k], vb[k], out_r, ve[k]);
            end
            $display("product: a=%0d b=%0d out_r=%0d expected=%0d", va[k], vb[k], out_r, ve[k]);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int rise [$];
        bit prev;
        bit bad_val;
        out_ready = 1'b1;
        in_a      = 8'd2;
        in_b      = 8'd3;
        in_valid  = 1'b1;
        prev      = 1'b0;
        bad_val   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && !prev) begin
                rise.push_back(c);
                if (out_r !== 8'd6) bad_val = 1'b1;
            end
            prev = out_valid;
        end
        in_valid = 1'b0;
        checks++;
        if (rise.size() < 3 || rise[1] - rise[0] != 10 || rise[2] - rise[1] != 10) begin
            errors++;
            $display("FAIL back_to_back_period: %0d results, spacing %0d, required >=3 at 10",
                     rise.size(), (rise.size() >= 2) ? rise[1] - rise[0] : -1);
        end
        checks++;
        if (bad_val) begin
            errors++;
            $display("FAIL back_to_back_value: a result differed, required 6");
        end
        $display("back_to_back: %0d results of 2*3", rise.size());
        for (int c = 0; c < 30; c++) begin
            if (in_ready) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        bit bad;
        out_ready = 1'b0;
        bad       = 1'b0;
        accept(8'd10, 8'd20, ok);
        wait_valid(lat);
        checks++;
        if (!ok || lat != 8 || out_r !== 8'd200) begin
            errors++;
            $display("FAIL bp_result: latency=%0d out_r=%0d, required 8 200", lat, out_r);
        end
        in_a     = 8'd1;
        in_b     = 8'd1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_r !== 8'd200 || in_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: out_valid=%b out_r=%0d in_ready=%b, required 1 200 0",
                     out_valid, out_r, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_r !== 8'd200) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b out_r=%0d, required 0 1 200",
                     out_valid, in_ready, out_r);
        end
        $display("backpressure: a=10 b=20 out_r=%0d held 5 cycles", out_r);
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int lat;
        bit pulse;
        out_ready = 1'b1;
        pulse     = 1'b0;
        accept(8'd100, 8'd100, ok);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_r !== 8'd0) begin
            errors++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b out_r=%0d, required 1 0 0",
                     in_ready, out_valid, out_r);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulse = 1'b1;
        end
        checks++;
        if (pulse) begin
            errors++;
            $display("FAIL midrun_no_pulse: out_valid pulsed after reset, required 0");
        end
        accept(8'd7, 8'd8, ok);
        wait_valid(lat);
        checks++;
        if (!ok || lat != 8 || out_r !== 8'd56) begin
            errors++;
            $display("FAIL midrun_after: latency=%0d out_r=%0d, required 8 56", lat, out_r);
        end
        $display("reset_mid_run: then a=7 b=8 out_r=%0d", out_r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_products();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
